// File: rtl/sr_latch.sv
// Clocked model of a cross-coupled NAND SR latch with active-low set/reset.
// S/R are sampled on the rising edge of clk. Q, Qbar and invalid are all
// register outputs, so they show the result of each edge from that edge on.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high; takes priority over S/R
//   S       set request, active-low
//   R       reset request, active-low
//   Q       latch output
//   Qbar    complementary output; equals ~Q except in the forbidden state
//   invalid high while the latch sits in the forbidden state (S=R=0)
//
// Parameters:
//   RESET_Q   Q value loaded by reset (Qbar takes ~RESET_Q)
//   RESOLVE_Q Q value taken when going from the forbidden state to hold
module sr_latch #(
  parameter logic RESET_Q   = 1'b0,
  parameter logic RESOLVE_Q = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qbar,
  output logic invalid
);

  // ST_FORBID records that the last sampled input was S=R=0. A following
  // hold then resolves to RESOLVE_Q instead of keeping both outputs high.
  typedef enum logic [1:0] {
    ST_Q0     = 2'b00,
    ST_Q1     = 2'b01,
    ST_FORBID = 2'b10
  } state_t;

  localparam int unsigned SR_W = 2;

  localparam state_t RESET_ST   = RESET_Q   ? ST_Q1 : ST_Q0;
  localparam state_t RESOLVE_ST = RESOLVE_Q ? ST_Q1 : ST_Q0;

  state_t         state;
  state_t         state_nxt;
  logic           q_nxt;
  logic           qbar_nxt;
  logic           invalid_nxt;
  logic [SR_W-1:0] sr;

  assign sr = {S, R};

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_ST;
      Q       <= RESET_Q;
      Qbar    <= ~RESET_Q;
      invalid <= 1'b0;
    end else begin
      state   <= state_nxt;
      Q       <= q_nxt;
      Qbar    <= qbar_nxt;
      invalid <= invalid_nxt;
    end
  end

  // NAND-latch truth table. Any S/R pattern other than the three explicit
  // codes, including X/Z in simulation, falls through to hold.
  always_comb begin
    state_nxt   = state;
    q_nxt       = Q;
    qbar_nxt    = Qbar;
    invalid_nxt = 1'b0;
    case (sr)
      2'b01: begin
        state_nxt = ST_Q1;
        q_nxt     = 1'b1;
        qbar_nxt  = 1'b0;
      end
      2'b10: begin
        state_nxt = ST_Q0;
        q_nxt     = 1'b0;
        qbar_nxt  = 1'b1;
      end
      2'b00: begin
        state_nxt   = ST_FORBID;
        q_nxt       = 1'b1;
        qbar_nxt    = 1'b1;
        invalid_nxt = 1'b1;
      end
      default: begin
        // Hold; leaving the forbidden state resolves deterministically.
        if (state == ST_FORBID) begin
          state_nxt = RESOLVE_ST;
          q_nxt     = RESOLVE_Q;
          qbar_nxt  = ~RESOLVE_Q;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sr_latch.sv
// Directed bench for sr_latch with default parameters (RESET_Q=0, RESOLVE_Q=0).
module tb_sr_latch;

  logic clk;
  logic rst;
  logic S;
  logic R;
  logic Q;
  logic Qbar;
  logic invalid;

  int passed = 0;
  int total  = 0;

  sr_latch dut (
    .clk    (clk),
    .rst    (rst),
    .S      (S),
    .R      (R),
    .Q      (Q),
    .Qbar   (Qbar),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic s, input logic r, input logic rs);
    @(negedge clk);
    S   = s;
    R   = r;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic q_e, input logic qb_e, input logic inv_e);
    total++;
    assert (Q === q_e) passed++;
    else $error("FAIL %s.Q: observed %b expected %b", tag, Q, q_e);
    total++;
    assert (Qbar === qb_e) passed++;
    else $error("FAIL %s.Qbar: observed %b expected %b", tag, Qbar, qb_e);
    total++;
    assert (invalid === inv_e) passed++;
    else $error("FAIL %s.invalid: observed %b expected %b", tag, invalid, inv_e);
  endtask

  initial begin
    S   = 1'b1;
    R   = 1'b1;
    rst = 1'b1;

    // Reset with unknown S/R.
    step(1'bx, 1'bx, 1'b1); chk("rst1", 1'b0, 1'b1, 1'b0);
    step(1'bx, 1'bx, 1'b1); chk("rst2", 1'b0, 1'b1, 1'b0);

    // Set, then hold for three cycles.
    step(1'b0, 1'b1, 1'b0); chk("set",   1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("hold1a", 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("hold1b", 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("hold1c", 1'b1, 1'b0, 1'b0);

    // Reset request, hold 0, set again.
    step(1'b1, 1'b0, 1'b0); chk("clr",   1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("hold0", 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk("set2",  1'b1, 1'b0, 1'b0);

    // Forbidden then hold: resolves to RESOLVE_Q=0 from Q=1.
    step(1'b0, 1'b0, 1'b0); chk("forb1",   1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0); chk("resolve", 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("resolve_hold", 1'b0, 1'b1, 1'b0);

    // Forbidden for two cycles, then reset request.
    step(1'b0, 1'b0, 1'b0); chk("forb2a",   1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0); chk("forb2b",   1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0); chk("forb2clr", 1'b0, 1'b1, 1'b0);

    // Forbidden straight to set.
    step(1'b0, 1'b0, 1'b0); chk("forb3",    1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0); chk("forb3set", 1'b1, 1'b0, 1'b0);

    // Reset overrides a set request, then the set takes effect.
    step(1'b0, 1'b1, 1'b1); chk("rst_over_set", 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0); chk("set_after_rst", 1'b1, 1'b0, 1'b0);

    // Reset while forbidden clears the forbidden history.
    step(1'b0, 1'b0, 1'b0); chk("forb4",      1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1); chk("rst_forb",   1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("hold_after_rst", 1'b0, 1'b1, 1'b0);

    // Set then hold after a reset-from-forbidden: must keep Q=1, not resolve.
    step(1'b0, 1'b1, 1'b0); chk("set3",  1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); chk("hold3", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
